// File: rtl/poly_ram_reader.sv
// Read-side master for the coefficient dual-port RAM: streams N/2 coefficient
// pairs {odd, even} in natural or bit-reversed order over a valid/ready link.
module poly_ram_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    bitrev_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    we_a_o,
  output logic                    we_b_o,
  output logic [ADDR_WIDTH-1:0]   addr_a_o,
  output logic [ADDR_WIDTH-1:0]   addr_b_o,
  output logic [DATA_WIDTH-1:0]   din_a_o,
  output logic [DATA_WIDTH-1:0]   din_b_o,
  input  logic [DATA_WIDTH-1:0]   dout_a_i,
  input  logic [DATA_WIDTH-1:0]   dout_b_i,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic [2*DATA_WIDTH-1:0] m_data_o
);

  localparam int KW = ADDR_WIDTH - 1;
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state_q;
  logic [KW-1:0]           k_q;
  logic                    bitrev_q;
  logic                    inflight_q;
  logic                    busy_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   addr_a_q;
  logic [ADDR_WIDTH-1:0]   addr_b_q;

  logic [1:0]              count_q;
  logic [1:0]              count_d;
  logic                    rd_ptr_q;
  logic                    wr_ptr_q;
  logic [2*DATA_WIDTH-1:0] mem_q [2];

  logic                    pop;
  logic                    issue;

  function automatic logic [ADDR_WIDTH-1:0] pair_addr(input logic [KW-1:0] k,
                                                      input logic odd,
                                                      input logic rev);
    logic [ADDR_WIDTH-1:0] a;
    logic [ADDR_WIDTH-1:0] r;
    a = {k, odd};
    for (int i = 0; i < ADDR_WIDTH; i++) r[i] = a[ADDR_WIDTH-1-i];
    return rev ? r : a;
  endfunction

  // Occupancy after this edge, counting the pair already in flight; a new
  // read is only issued if its data is guaranteed a slot when it lands.
  always_comb begin
    pop     = (count_q != 2'd0) && m_ready_i;
    count_d = count_q + 2'(inflight_q) - 2'(pop);
    issue   = (state_q == S_RUN) && (count_d < 2'd2);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      bitrev_q   <= 1'b0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
    end else begin
      inflight_q <= issue;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            bitrev_q <= bitrev_i;
            k_q      <= '0;
            addr_a_q <= pair_addr('0, 1'b0, bitrev_i);
            addr_b_q <= pair_addr('0, 1'b1, bitrev_i);
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (k_q == K_LAST) begin
              state_q <= S_DRAIN;
            end else begin
              k_q      <= k_q + KW'(1);
              addr_a_q <= pair_addr(k_q + KW'(1), 1'b0, bitrev_q);
              addr_b_q <= pair_addr(k_q + KW'(1), 1'b1, bitrev_q);
            end
          end
        end
        S_DRAIN: begin
          if (count_d == 2'd0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      if (inflight_q) begin
        mem_q[wr_ptr_q] <= {dout_b_i, dout_a_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign we_a_o    = 1'b0;
  assign we_b_o    = 1'b0;
  assign din_a_o   = '0;
  assign din_b_o   = '0;
  assign addr_a_o  = addr_a_q;
  assign addr_b_o  = addr_b_q;
  assign m_valid_o = (count_q != 2'd0);
  assign m_data_o  = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_poly_ram_reader.sv
// Bench for poly_ram_reader: RAM model plus a reference built from index
// arithmetic; directed passes with random data and random backpressure.
module tb_poly_ram_reader;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int NB = 1 << (AW - 1);

  logic          clk = 1'b0;
  logic          rst, start, bitrev, m_ready;
  logic          busy, done, we_a, we_b, m_valid;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;
  logic [2*DW-1:0] m_data;

  logic [DW-1:0]   ram [1 << AW];
  logic [2*DW-1:0] got [NB];

  int n_assert = 0;
  int n_fail   = 0;

  poly_ram_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .bitrev_i(bitrev),
    .busy_o(busy), .done_o(done), .we_a_o(we_a), .we_b_o(we_b),
    .addr_a_o(addr_a), .addr_b_o(addr_b), .din_a_o(din_a), .din_b_o(din_b),
    .dout_a_i(dout_a), .dout_b_i(dout_b),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dout_a <= ram[addr_a];
    dout_b <= ram[addr_b];
  end

  function automatic int rev_n(input int a);
    int r = 0;
    for (int i = 0; i < AW; i++) if (((a >> i) & 1) == 1) r += 1 << (AW - 1 - i);
    return r;
  endfunction

  function automatic logic [2*DW-1:0] exp_beat(input int k, input bit br);
    int ia = 2 * k;
    int ib = 2 * k + 1;
    if (br) begin
      ia = rev_n(ia);
      ib = rev_n(ib);
    end
    return {ram[ib], ram[ia]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // rmode: 0 = always ready, 1 = random ready, 2 = not ready for 20 cycles
  task automatic run_pass(input string name, input bit br, input int rmode,
                          input int restart_at, input int abort_at);
    int beats = 0, dones = 0, c = 0, first_valid = -1, first_hs = -1;
    int last_hs = -1, done_cyc = -1, gaps = 0, abort_c = -1;
    bit we_bad = 0, din_bad = 0, stall_bad = 0, busy_bad = 0, addr_moved = 0;
    bit aborted = 0, restarted = 0, finished = 0;
    logic pv = 1'b0, pr = 1'b0, r;
    logic [2*DW-1:0] pd = '0;
    logic [AW-1:0] a0 = '0, b0 = '0;

    @(negedge clk);
    start   = 1'b1;
    bitrev  = br;
    m_ready = (rmode == 0);
    @(negedge clk);
    start  = 1'b0;
    bitrev = ~br;
    c = 1;
    while (!finished && c < 3000) begin
      start = 1'b0;
      if (we_a !== 1'b0 || we_b !== 1'b0) we_bad = 1;
      if (din_a !== '0 || din_b !== '0) din_bad = 1;
      if (aborted) begin
        if (done === 1'b1) dones++;
        if (c == abort_c + 2) rst = 1'b0;
        if (c >= abort_c + 10) finished = 1;
      end else if (abort_at >= 0 && beats == abort_at) begin
        rst = 1'b1;
        #1;
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_done"}, done, 0);
        check({name, "_rst_valid"}, m_valid, 0);
        check({name, "_rst_data"}, m_data, 0);
        check({name, "_rst_addr"}, {addr_a, addr_b}, 0);
        aborted = 1;
        abort_c = c;
        m_ready = 1'b0;
      end else begin
        if (dones == 0 && busy !== 1'b1) busy_bad = 1;
        if (done_cyc >= 0 && busy !== 1'b0) busy_bad = 1;
        if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd)) stall_bad = 1;
        if (m_valid === 1'b1 && first_valid < 0) first_valid = c;
        if (rmode == 2 && c == 3) begin a0 = addr_a; b0 = addr_b; end
        if (rmode == 2 && c > 3 && c <= 20 && (addr_a !== a0 || addr_b !== b0)) addr_moved = 1;
        if (done === 1'b1) begin dones++; done_cyc = c; end
        case (rmode)
          0:       r = 1'b1;
          1:       r = 1'($urandom_range(0, 1));
          default: r = (c > 20);
        endcase
        m_ready = r;
        if (rmode != 1 && r && beats > 0 && beats < NB && m_valid !== 1'b1) gaps++;
        if (m_valid === 1'b1 && r) begin
          if (beats < NB) begin
            check($sformatf("%s_beat%0d", name, beats), m_data, exp_beat(beats, br));
            got[beats] = m_data;
          end
          if (first_hs < 0) first_hs = c;
          beats++;
          last_hs = c;
        end
        if (restart_at >= 0 && !restarted && beats == restart_at) begin
          start     = 1'b1;
          restarted = 1;
        end
        pv = m_valid;
        pr = r;
        pd = m_data;
        if (done_cyc >= 0 && c >= done_cyc + 3) finished = 1;
      end
      @(negedge clk);
      c++;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    check({name, "_timeout"}, finished, 1);
    check({name, "_we_zero"}, we_bad, 0);
    check({name, "_din_zero"}, din_bad, 0);
    if (abort_at >= 0) begin
      check({name, "_no_done"}, dones, 0);
      check({name, "_beats_before_rst"}, beats, abort_at);
      check({name, "_idle_after_rst"}, busy, 0);
    end else begin
      check({name, "_beat_count"}, beats, NB);
      check({name, "_done_count"}, dones, 1);
      check({name, "_done_after_last"}, done_cyc, last_hs + 1);
      check({name, "_busy"}, busy_bad, 0);
      check({name, "_stall_stable"}, stall_bad, 0);
      check({name, "_first_valid"}, first_valid, 3);
      if (rmode == 0) check({name, "_last_beat_cycle"}, last_hs, 3 + NB - 1);
      if (rmode == 2) begin
        check({name, "_addr_frozen"}, addr_moved, 0);
        check({name, "_first_hs"}, first_hs, 21);
        check({name, "_last_beat_cycle"}, last_hs, 21 + NB - 1);
      end
      if (rmode != 1) check({name, "_no_gap"}, gaps, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bitrev = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(i);
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", m_valid, 0);
    check("reset_data", m_data, 0);
    check("reset_addr_a", addr_a, 0);
    check("reset_addr_b", addr_b, 0);
    check("reset_we", {we_a, we_b}, 0);
    check("reset_din", {din_a, din_b}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    run_pass("nat", 1'b0, 0, -1, -1);
    run_pass("rev", 1'b1, 0, -1, -1);
    check("rev_beat0_const", got[0], 32'h0080_0000);
    check("rev_beat1_const", got[1], 32'h00C0_0040);
    check("rev_beat127_const", got[NB-1], 32'h00FF_007F);

    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'($urandom);
    run_pass("rnd_nat", 1'b0, 1, -1, -1);
    run_pass("rnd_rev", 1'b1, 1, -1, -1);
    run_pass("stall", 1'b0, 2, -1, -1);
    run_pass("restart", 1'b1, 1, 50, -1);
    run_pass("abort", 1'b0, 0, -1, 60);
    run_pass("fresh", 1'b0, 0, -1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
